// File: rtl/clk_rst_pkg.sv
// Shared definitions for the reset sequencer: FSM encoding, default timing
// constants and a constant-evaluable ceil(log2) helper.
package clk_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int DEF_LOCK_STABLE = 1024;
    localparam int DEF_SEQ_GAP     = 16;

    // ceil(log2(n)); returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_ce_div.sv
// Single-channel clock-enable divider: one-cycle strobe every r cycles,
// r = max(ratio, 1), with the ratio sampled on release and at every wrap.
module clk_ce_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk_100Mhz,
    input  logic             reset,
    input  logic             ch_rst,
    input  logic [DIV_W-1:0] ratio,
    output logic             ce
);

    logic             active;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] r_q;
    logic [DIV_W-1:0] r_eff;

    assign r_eff = (ratio == '0) ? DIV_W'(1) : ratio;

    // ch_rst is the value the channel reset takes at this edge, so the
    // divider clears (and starts) on the very edge the reset changes.
    always_ff @(posedge clk_100Mhz or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            cnt    <= '0;
            r_q    <= '0;
            ce     <= 1'b0;
        end else if (ch_rst) begin
            active <= 1'b0;
            cnt    <= '0;
            r_q    <= '0;
            ce     <= 1'b0;
        end else if (!active) begin
            active <= 1'b1;
            cnt    <= '0;
            r_q    <= r_eff;
            ce     <= 1'b0;
        end else if (cnt == r_q - DIV_W'(1)) begin
            cnt    <= '0;
            r_q    <= r_eff;
            ce     <= 1'b1;
        end else begin
            cnt    <= cnt + DIV_W'(1);
            ce     <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_rst_seq.sv
// Reset sequencer: debounces PLL lock, releases per-channel resets in order
// SEQ_GAP cycles apart, and drives a programmable clock-enable per channel.
module clk_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int DIV_W       = 8,
    parameter int LOCK_STABLE = DEF_LOCK_STABLE,
    parameter int SEQ_GAP     = DEF_SEQ_GAP
) (
    input  logic                    clk_100Mhz,
    input  logic                    reset,
    input  logic                    pll_locked,
    input  logic [NUM_CH*DIV_W-1:0] div_ratio,
    output logic [NUM_CH-1:0]       ch_reset,
    output logic [NUM_CH-1:0]       ch_ce,
    output logic                    all_ready,
    output logic [7:0]              lock_lost_cnt,
    output state_t                  fsm_state
);

    localparam int SW = (clog2(LOCK_STABLE + 1) > 0) ? clog2(LOCK_STABLE + 1) : 1;
    localparam int GW = (SEQ_GAP > 1) ? clog2(SEQ_GAP) : 1;
    localparam int IW = (NUM_CH > 1) ? clog2(NUM_CH) : 1;

    localparam logic [NUM_CH-1:0] CH_ONE   = NUM_CH'(1);
    localparam logic [SW-1:0]     STAB_END = SW'(LOCK_STABLE);
    localparam logic [GW-1:0]     GAP_END  = GW'(SEQ_GAP - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(NUM_CH - 1);

    logic        sync1, lk_s;
    state_t      state, state_n;
    logic [SW-1:0] stab_cnt, stab_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic [IW-1:0] idx, idx_n;
    logic [NUM_CH-1:0] reset_n;
    logic        ready_n;
    logic [7:0]  lost_n;
    logic        lose;

    assign fsm_state = state;

    always_ff @(posedge clk_100Mhz or posedge reset) begin
        if (reset) begin
            sync1         <= 1'b0;
            lk_s          <= 1'b0;
            state         <= WAIT_LOCK;
            stab_cnt      <= '0;
            gap_cnt       <= '0;
            idx           <= '0;
            ch_reset      <= '1;
            all_ready     <= 1'b0;
            lock_lost_cnt <= '0;
        end else begin
            sync1         <= pll_locked;
            lk_s          <= sync1;
            state         <= state_n;
            stab_cnt      <= stab_n;
            gap_cnt       <= gap_n;
            idx           <= idx_n;
            ch_reset      <= reset_n;
            all_ready     <= ready_n;
            lock_lost_cnt <= lost_n;
        end
    end

    always_comb begin
        state_n = state;
        stab_n  = stab_cnt;
        gap_n   = gap_cnt;
        idx_n   = idx;
        reset_n = ch_reset;
        ready_n = all_ready;
        lost_n  = lock_lost_cnt;
        lose    = 1'b0;
        case (state)
            WAIT_LOCK: begin
                reset_n = '1;
                ready_n = 1'b0;
                stab_n  = '0;
                gap_n   = '0;
                idx_n   = '0;
                if (lk_s) begin
                    state_n = STABLE;
                    stab_n  = SW'(1);
                end
            end
            STABLE: begin
                if (!lk_s) begin
                    lose = 1'b1;
                end else if (stab_cnt == STAB_END) begin
                    reset_n[0] = 1'b0;
                    stab_n     = '0;
                    gap_n      = '0;
                    if (NUM_CH == 1) begin
                        state_n = RUN;
                        ready_n = 1'b1;
                    end else begin
                        state_n = RELEASE;
                        idx_n   = IW'(1);
                    end
                end else begin
                    stab_n = stab_cnt + SW'(1);
                end
            end
            RELEASE: begin
                if (!lk_s) begin
                    lose = 1'b1;
                end else if (gap_cnt == GAP_END) begin
                    reset_n = ch_reset & ~(CH_ONE << idx);
                    gap_n   = '0;
                    if (idx == IDX_LAST) begin
                        state_n = RUN;
                        ready_n = 1'b1;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end else begin
                    gap_n = gap_cnt + GW'(1);
                end
            end
            RUN: begin
                if (!lk_s) lose = 1'b1;
            end
            default: state_n = WAIT_LOCK;
        endcase

        // Loss while debouncing only restarts; later losses are counted.
        if (lose) begin
            state_n = WAIT_LOCK;
            reset_n = '1;
            ready_n = 1'b0;
            stab_n  = '0;
            gap_n   = '0;
            idx_n   = '0;
            if (state != STABLE && lock_lost_cnt != 8'hFF) begin
                lost_n = lock_lost_cnt + 8'd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_div
        clk_ce_div #(
            .DIV_W(DIV_W)
        ) u_div (
            .clk_100Mhz(clk_100Mhz),
            .reset     (reset),
            .ch_rst    (reset_n[i]),
            .ratio     (div_ratio[i*DIV_W +: DIV_W]),
            .ce        (ch_ce[i])
        );
    end

endmodule

// File: tb/tb_clk_rst_seq.sv
// Bench for clk_rst_seq: per-cycle expected words derived from the release
// and strobe timetable, queued on stimulus and compared cycle by cycle.
module tb_clk_rst_seq;

    localparam int NUM_CH = 3;
    localparam int DIV_W  = 8;
    localparam int LS     = 8;
    localparam int SG     = 4;
    localparam int W      = 17;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    pll_locked = 1'b0;
    logic [NUM_CH*DIV_W-1:0] div_ratio;
    logic [NUM_CH-1:0]       ch_reset;
    logic [NUM_CH-1:0]       ch_ce;
    logic                    all_ready;
    logic [7:0]              lock_lost_cnt;
    logic [1:0]              fsm_state;

    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int exp_lost;
    int t_org[NUM_CH];
    int r_cur[NUM_CH];

    clk_rst_seq #(
        .NUM_CH     (NUM_CH),
        .DIV_W      (DIV_W),
        .LOCK_STABLE(LS),
        .SEQ_GAP    (SG)
    ) dut (
        .clk_100Mhz   (clk),
        .reset        (reset),
        .pll_locked   (pll_locked),
        .div_ratio    (div_ratio),
        .ch_reset     (ch_reset),
        .ch_ce        (ch_ce),
        .all_ready    (all_ready),
        .lock_lost_cnt(lock_lost_cnt),
        .fsm_state    (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] obs();
        return {fsm_state, lock_lost_cnt, all_ready, ch_ce, ch_reset};
    endfunction

    function automatic logic [W-1:0] reset_word(input int lost);
        return {2'd0, 8'(lost), 1'b0, 3'b000, 3'b111};
    endfunction

    // Expected outputs k edges after the edge that first captures lock=1.
    function automatic logic [W-1:0] exp_word(input int k);
        logic [2:0] rs, ce;
        logic       rdy;
        logic [1:0] st;
        int         rel_last;
        rel_last = 2 + LS + (NUM_CH - 1) * SG;
        for (int i = 0; i < NUM_CH; i++) begin
            rs[i] = (k < 2 + LS + i * SG);
            ce[i] = (k > t_org[i]) && (((k - t_org[i]) % r_cur[i]) == 0);
        end
        rdy = (k >= rel_last);
        if (k < 2)                st = 2'd0;
        else if (k < 2 + LS)      st = 2'd1;
        else if (k < rel_last)    st = 2'd2;
        else                      st = 2'd3;
        return {st, 8'(exp_lost), rdy, ce, rs};
    endfunction

    task automatic set_defaults();
        div_ratio = {8'd3, 8'd1, 8'd2};
        r_cur[0] = 2;
        r_cur[1] = 1;
        r_cur[2] = 3;
        for (int i = 0; i < NUM_CH; i++) t_org[i] = 2 + LS + i * SG;
    endtask

    task automatic run_seq(input int k0, input int n);
        for (int k = k0; k < k0 + n; k++) exp_q.push_back(exp_word(k));
        for (int k = k0; k < k0 + n; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("seq_k%0d", k), obs(), exp_q.pop_front());
        end
    endtask

    task automatic hold_reset(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(reset_word(exp_lost));
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("held_rst", obs(), exp_q.pop_front());
        end
    endtask

    initial begin
        set_defaults();
        exp_lost = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("por", obs(), reset_word(0));
        reset = 1'b0;
        hold_reset(2);

        // Debounce restart: lock drops during STABLE, timeline starts over.
        pll_locked = 1'b1;
        run_seq(0, 5);
        pll_locked = 1'b0;
        run_seq(5, 2);
        pll_locked = 1'b1;
        run_seq(0, 30);

        // Loss in RUN: two sync edges, then everything back in reset.
        pll_locked = 1'b0;
        run_seq(30, 2);
        exp_lost = 1;
        hold_reset(3);

        // Relock, then ratio changes mid-period on ch0 (2->5) and ch2 (3->0).
        pll_locked = 1'b1;
        run_seq(0, 24);
        div_ratio[7:0] = 8'd5;
        t_org[0] = 19;
        r_cur[0] = 5;
        run_seq(24, 7);
        div_ratio[23:16] = 8'd0;
        t_org[2] = 32;
        r_cur[2] = 1;
        run_seq(31, 15);

        // Repeated RUN losses drive the counter into saturation.
        for (int n = 0; n < 261; n++) begin
            pll_locked = 1'b0;
            repeat (4) @(negedge clk);
            exp_lost = (exp_lost < 255) ? exp_lost + 1 : 255;
            check("lost_cnt", W'(lock_lost_cnt), W'(exp_lost));
            if (n < 260) begin
                int c;
                pll_locked = 1'b1;
                c = 0;
                while (!all_ready && c < 60) begin
                    @(negedge clk);
                    c++;
                end
                check("relock_ready", W'(all_ready), W'(1));
            end
        end

        // Async reset between edges while ch0 is strobing in RELEASE.
        set_defaults();
        pll_locked = 1'b1;
        run_seq(0, 13);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst", obs(), reset_word(0));
        @(negedge clk);
        check("async_hold", obs(), reset_word(0));
        reset = 1'b0;
        exp_lost = 0;
        hold_reset(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
